// File: rtl/flag_branch_unit_pkg.sv
// Shared opcode/condition encodings and the per-opcode flag write mask
// for the Z/V/N flag register and branch resolver.
package flag_branch_unit_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  localparam logic [2:0] CC_NE   = 3'b000;
  localparam logic [2:0] CC_EQ   = 3'b001;
  localparam logic [2:0] CC_GT   = 3'b010;
  localparam logic [2:0] CC_LT   = 3'b011;
  localparam logic [2:0] CC_GTE  = 3'b100;
  localparam logic [2:0] CC_LTE  = 3'b101;
  localparam logic [2:0] CC_OVFL = 3'b110;
  localparam logic [2:0] CC_UNC  = 3'b111;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  // Which flags an opcode is allowed to overwrite; everything else holds.
  function automatic flags_t flag_wmask(input logic [3:0] op);
    flags_t m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:                 m = '{z: 1'b1, v: 1'b1, n: 1'b1};
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = '{z: 1'b1, v: 1'b0, n: 1'b0};
      default:                        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX-stage flag update and branch resolve signals between the pipeline
// (master) and the flag/branch unit (slave).
interface flag_branch_unit_if #(parameter int WIDTH = 16);
  logic             ex_valid;
  logic [3:0]       ex_opcode;
  logic [WIDTH-1:0] ex_result;
  logic             ex_ovfl;
  logic             stall;
  logic             flush;
  logic             br_valid;
  logic [2:0]       br_cond;
  logic             z_flag;
  logic             v_flag;
  logic             n_flag;
  logic             br_taken;

  modport master (
    output ex_valid, ex_opcode, ex_result, ex_ovfl, stall, flush, br_valid, br_cond,
    input  z_flag, v_flag, n_flag, br_taken
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_result, ex_ovfl, stall, flush, br_valid, br_cond,
    output z_flag, v_flag, n_flag, br_taken
  );
endinterface

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// Pure combinational evaluation of a 3-bit condition code against Z/V/N.
module flag_branch_unit_branch_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       take
);
  always_comb begin
    take = 1'b0;
    case (cond)
      CC_NE:   take = ~z;
      CC_EQ:   take = z;
      CC_GT:   take = ~z & ~n;
      CC_LT:   take = n;
      CC_GTE:  take = z | ~n;
      CC_LTE:  take = n | z;
      CC_OVFL: take = v;
      CC_UNC:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end
endmodule

// File: rtl/flag_branch_unit.sv
// Z/V/N flag register fed from EX results, plus branch resolution against
// either registered or same-cycle (bypassed) flags.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int BYPASS = 1,
  parameter int WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  flag_branch_unit_if.slave bus
);
  flags_t flags, eff, wm, cond_flags;
  logic   upd, take;

  assign upd = bus.ex_valid & ~bus.stall & ~bus.flush;
  assign wm  = flag_wmask(bus.ex_opcode);

  // eff is exactly what the register will load on this edge (absent reset).
  always_comb begin
    eff = flags;
    if (upd) begin
      if (wm.z) eff.z = (bus.ex_result == '0);
      if (wm.v) eff.v = bus.ex_ovfl;
      if (wm.n) eff.n = bus.ex_result[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flags <= '0;
    else     flags <= eff;
  end

  assign cond_flags = (BYPASS != 0) ? eff : flags;

  flag_branch_unit_branch_cond_eval u_cond (
    .cond (bus.br_cond),
    .z    (cond_flags.z),
    .v    (cond_flags.v),
    .n    (cond_flags.n),
    .take (take)
  );

  assign bus.z_flag   = flags.z;
  assign bus.v_flag   = flags.v;
  assign bus.n_flag   = flags.n;
  assign bus.br_taken = bus.br_valid & take & ~rst;
endmodule
